multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multicycle control FSM for a RISC-V style core.
// It sequences FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK] and drives
// the datapath strobes. A memory request that waits too long halts the core.
// An illegal opcode also halts the core. Only RESET leaves HALT.
module multicycle_control #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OPCODE,
  input  logic       BRANCH_TAKEN,
  input  logic       MEM_READY,
  output logic       MEM_REQ,
  output logic       MEM_WE,
  output logic       ADDR_SEL,
  output logic       IR_WRITE,
  output logic [2:0] ALUOP,
  output logic       REG_WRITE,
  output logic [1:0] WB_SEL,
  output logic       PC_WRITE,
  output logic [1:0] PC_SEL,
  output logic       TRAP,
  output logic [1:0] TRAP_CAUSE
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [2:0] C_R     = 3'b000;
  localparam logic [2:0] C_I     = 3'b001;
  localparam logic [2:0] C_LOAD  = 3'b010;
  localparam logic [2:0] C_STORE = 3'b011;
  localparam logic [2:0] C_BR    = 3'b100;
  localparam logic [2:0] C_LUI   = 3'b101;
  localparam logic [2:0] C_AUIPC = 3'b110;
  localparam logic [2:0] C_JMP   = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The fault fires on the TIMEOUT_CYCLES-th consecutive wait cycle. A MEM_READY
  // in that same cycle is an ordinary completion.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] cls_q, cls_d;
  logic       jalr_q, jalr_d;      // separates JALR from JAL inside class 111
  logic [7:0] wait_q, wait_d;
  logic [1:0] cause_q, cause_d;

  logic [2:0] opc_cls;
  logic       opc_jalr;
  logic       opc_legal;
  logic       mem_phase;
  logic       timeout_hit;

  // Map the opcode to an instruction class.
  always_comb begin
    opc_cls   = C_R;
    opc_jalr  = 1'b0;
    opc_legal = 1'b1;
    unique case (OPCODE)
      OP_R:     opc_cls = C_R;
      OP_I:     opc_cls = C_I;
      OP_LOAD:  opc_cls = C_LOAD;
      OP_STORE: opc_cls = C_STORE;
      OP_BR:    opc_cls = C_BR;
      OP_LUI:   opc_cls = C_LUI;
      OP_AUIPC: opc_cls = C_AUIPC;
      OP_JAL:   opc_cls = C_JMP;
      OP_JALR: begin
        opc_cls  = C_JMP;
        opc_jalr = 1'b1;
      end
      default:  opc_legal = 1'b0;
    endcase
  end

  assign mem_phase   = (state_q == S_FETCH) || (state_q == S_MEMORY);
  assign timeout_hit = mem_phase && !MEM_READY && (wait_q == WAIT_LAST);

  // State, class, wait counter and trap cause registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_FETCH;
      cls_q   <= C_R;
      jalr_q  <= 1'b0;
      wait_q  <= 8'd0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      jalr_q  <= jalr_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic. The wait counter counts only while the request stays open.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    jalr_d  = jalr_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH: begin
        if (MEM_READY) state_d = S_DECODE;
        else if (timeout_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        cls_d  = opc_cls;
        jalr_d = opc_jalr;
        if (opc_legal) state_d = S_EXECUTE;
        else begin
          state_d = S_HALT;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        if (cls_q == C_LOAD || cls_q == C_STORE) state_d = S_MEMORY;
        else if (cls_q == C_BR)                  state_d = S_FETCH;
        else                                     state_d = S_WRITEBACK;
      end
      S_MEMORY: begin
        if (MEM_READY) state_d = (cls_q == C_STORE) ? S_FETCH : S_WRITEBACK;
        else if (timeout_hit) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
    if (mem_phase && !MEM_READY && state_d == state_q) wait_d = wait_q + 8'd1;
    else                                                wait_d = 8'd0;
  end

  // Output decode. Outputs are forced low during a reset cycle so that an
  // in-flight request is dropped without issuing any strobe.
  always_comb begin
    MEM_REQ    = 1'b0;
    MEM_WE     = 1'b0;
    ADDR_SEL   = 1'b0;
    IR_WRITE   = 1'b0;
    ALUOP      = 3'b000;
    REG_WRITE  = 1'b0;
    WB_SEL     = 2'b00;
    PC_WRITE   = 1'b0;
    PC_SEL     = 2'b00;
    TRAP       = 1'b0;
    TRAP_CAUSE = 2'b00;
    if (!RESET) begin
      TRAP_CAUSE = cause_q;
      unique case (state_q)
        S_FETCH: begin
          MEM_REQ  = 1'b1;
          IR_WRITE = MEM_READY;
        end
        S_DECODE: ;
        S_EXECUTE: begin
          ALUOP = cls_q;
          if (cls_q == C_BR) begin
            PC_WRITE = 1'b1;
            PC_SEL   = BRANCH_TAKEN ? 2'b01 : 2'b00;
          end
        end
        S_MEMORY: begin
          ALUOP    = cls_q;
          MEM_REQ  = 1'b1;
          ADDR_SEL = 1'b1;
          MEM_WE   = (cls_q == C_STORE);
          PC_WRITE = MEM_READY && (cls_q == C_STORE);
        end
        S_WRITEBACK: begin
          ALUOP     = cls_q;
          REG_WRITE = 1'b1;
          PC_WRITE  = 1'b1;
          if (cls_q == C_LOAD)     WB_SEL = 2'b01;
          else if (cls_q == C_JMP) WB_SEL = 2'b10;
          if (cls_q == C_JMP)      PC_SEL = jalr_q ? 2'b10 : 2'b01;
        end
        S_HALT: TRAP = 1'b1;
        default: TRAP = 1'b1;
      endcase
    end
  end

endmodule
